// File: rtl/rf_pkg.sv
// Shared encodings for the extended register file: access-size codes and
// the ECALL keyboard-read FSM states.
package rf_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ecall_state_e;

endpackage

// File: rtl/rf_ext_unit.sv
// Combinational sign/zero extender: byte or half from the low bits of data,
// word (and the reserved 2'b11 code) passes the full value through.
module rf_ext_unit
  import rf_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic fill_b;
  logic fill_h;

  assign fill_b = ~is_unsigned & data[7];
  assign fill_h = ~is_unsigned & data[15];

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{(XLEN-8){fill_b}}, data[7:0]};
      SZ_HALF: result = {{(XLEN-16){fill_h}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/reg_file_ext.sv
// Parametrised integer register file with load-extension write-back,
// store-data narrowing, write->read bypass and an ECALL keyboard-read FSM.
module reg_file_ext
  import rf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ECALL_RD = 10,
  parameter int TUBE_IDX = 31,
  parameter int LED_IDX  = 30,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic [1:0]      st_size_i,
  input  logic            is_store_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic            wb_sel_mem_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_unsigned_i,
  input  logic            is_load_i,
  input  logic            ecall_req_i,
  input  logic            key_valid_i,
  input  logic [XLEN-1:0] key_data_i,
  output logic            key_ready_o,
  output logic            ecall_busy_o,
  output logic [XLEN-1:0] tube_o,
  output logic [XLEN-1:0] led_o,
  output ecall_state_e    ecall_state
);

  localparam logic [AW-1:0] ECALL_ADDR = AW'(ECALL_RD);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] wb_src;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rs1_raw;
  logic [XLEN-1:0] rs2_raw;
  logic            wb_commit;
  logic            key_commit;
  ecall_state_e    state_q;
  ecall_state_e    state_d;

  assign wb_src    = wb_sel_mem_i ? mem_data_i : alu_data_i;
  assign wb_commit = wb_en_i & ~stall_i & (wb_addr_i != '0);

  rf_ext_unit #(.XLEN(XLEN)) u_ld_ext (
    .data        (wb_src),
    .size        (is_load_i ? ld_size_i : SZ_WORD),
    .is_unsigned (ld_unsigned_i),
    .result      (wb_data)
  );

  // Keyboard handshake: a value transfers on the rising edge where
  // key_valid_i and key_ready_o are both high; key_ready_o is high only in WAIT.
  always_comb begin
    state_d      = state_q;
    key_ready_o  = 1'b0;
    ecall_busy_o = 1'b0;
    key_commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ecall_busy_o = ecall_req_i;
        if (ecall_req_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ecall_busy_o = 1'b1;
        key_ready_o  = 1'b1;
        key_commit   = key_valid_i;
        if (key_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign ecall_state = state_q;

  // Keyboard write is placed after the write-back so it wins on ECALL_RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_commit)  regs[wb_addr_i]  <= wb_data;
      if (key_commit) regs[ECALL_ADDR] <= key_data_i;
    end
  end

  always_comb begin
    rs1_raw = regs[rs1_addr_i];
    if (rs1_addr_i == '0)
      rs1_raw = '0;
    else if (BYPASS && wb_commit && (rs1_addr_i == wb_addr_i))
      rs1_raw = wb_data;
  end

  always_comb begin
    rs2_raw = regs[rs2_addr_i];
    if (rs2_addr_i == '0)
      rs2_raw = '0;
    else if (BYPASS && wb_commit && (rs2_addr_i == wb_addr_i))
      rs2_raw = wb_data;
  end

  assign rs1_data_o = rs1_raw;

  rf_ext_unit #(.XLEN(XLEN)) u_st_narrow (
    .data        (rs2_raw),
    .size        (is_store_i ? st_size_i : SZ_WORD),
    .is_unsigned (1'b0),
    .result      (rs2_data_o)
  );

  assign tube_o = regs[TUBE_IDX];
  assign led_o  = regs[LED_IDX];

endmodule

// File: tb/tb_reg_file_ext.sv
// Directed bench for reg_file_ext: one bypassing instance and one
// non-bypassing instance driven from the same stimulus.
module tb_reg_file_ext;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i;
  logic [AW-1:0]   rs1_addr_i, rs2_addr_i, wb_addr_i;
  logic [1:0]      st_size_i, ld_size_i;
  logic            is_store_i, wb_en_i, wb_sel_mem_i, ld_unsigned_i, is_load_i;
  logic [XLEN-1:0] alu_data_i, mem_data_i, key_data_i;
  logic            ecall_req_i, key_valid_i;

  logic [XLEN-1:0] rs1_a, rs2_a, tube_a, led_a;
  logic [XLEN-1:0] rs1_b, rs2_b, tube_b, led_b;
  logic            ready_a, busy_a, ready_b, busy_b;
  ecall_state_e    st_a, st_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_ext #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_a), .rs2_data_o(rs2_a),
    .st_size_i(st_size_i), .is_store_i(is_store_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_sel_mem_i(wb_sel_mem_i),
    .alu_data_i(alu_data_i), .mem_data_i(mem_data_i),
    .ld_size_i(ld_size_i), .ld_unsigned_i(ld_unsigned_i), .is_load_i(is_load_i),
    .ecall_req_i(ecall_req_i), .key_valid_i(key_valid_i), .key_data_i(key_data_i),
    .key_ready_o(ready_a), .ecall_busy_o(busy_a),
    .tube_o(tube_a), .led_o(led_a), .ecall_state(st_a)
  );

  reg_file_ext #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_b), .rs2_data_o(rs2_b),
    .st_size_i(st_size_i), .is_store_i(is_store_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_sel_mem_i(wb_sel_mem_i),
    .alu_data_i(alu_data_i), .mem_data_i(mem_data_i),
    .ld_size_i(ld_size_i), .ld_unsigned_i(ld_unsigned_i), .is_load_i(is_load_i),
    .ecall_req_i(ecall_req_i), .key_valid_i(key_valid_i), .key_data_i(key_data_i),
    .key_ready_o(ready_b), .ecall_busy_o(busy_b),
    .tube_o(tube_b), .led_o(led_b), .ecall_state(st_b)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; wb_addr_i = 0;
    st_size_i = SZ_WORD; ld_size_i = SZ_WORD; is_store_i = 0; wb_en_i = 0;
    wb_sel_mem_i = 0; ld_unsigned_i = 0; is_load_i = 0;
    alu_data_i = 0; mem_data_i = 0; key_data_i = 0;
    ecall_req_i = 0; key_valid_i = 0;
  endtask

  task automatic wb_alu(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_en_i = 1; wb_addr_i = a; wb_sel_mem_i = 0; alu_data_i = d; is_load_i = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    tick();

    // Reset state
    rs1_addr_i = 5; rs2_addr_i = 31; #1;
    check("rst_rs1", rs1_a, 0);
    check("rst_rs2", rs2_a, 0);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_ready", {31'd0, ready_a}, 0);
    check("rst_state", {31'd0, st_a}, {31'd0, ST_IDLE});

    // Populate x5, tube and led, then pulse reset between edges
    wb_alu(5, 32'h1234); tick();
    wb_alu(31, 32'hCAFE_0001); tick();
    wb_alu(30, 32'h0000_0055); tick();
    wb_en_i = 0; #1;
    check("x5_written", rs1_a, 32'h1234);
    check("tube_written", tube_a, 32'hCAFE_0001);
    check("led_written", led_a, 32'h0000_0055);
    #2 reset = 0;
    #1;
    check("async_rst_x5", rs1_a, 0);
    check("async_rst_tube", tube_a, 0);
    check("async_rst_led", led_a, 0);
    reset = 1;
    tick();

    // Load extension into x6, also seen through the bypass
    wb_en_i = 1; wb_addr_i = 6; wb_sel_mem_i = 1; is_load_i = 1;
    mem_data_i = 32'h0000_80F0; alu_data_i = 32'h0BAD_0BAD;
    ld_size_i = SZ_BYTE; ld_unsigned_i = 0; rs1_addr_i = 6; #1;
    check("ld_b_bypass", rs1_a, 32'hFFFF_FFF0);
    tick(); wb_en_i = 0; #1;
    check("ld_b_signed", rs1_a, 32'hFFFF_FFF0);
    wb_en_i = 1; ld_unsigned_i = 1; tick(); wb_en_i = 0; #1;
    check("ld_b_unsigned", rs1_a, 32'h0000_00F0);
    wb_en_i = 1; ld_unsigned_i = 0; ld_size_i = SZ_HALF; tick(); wb_en_i = 0; #1;
    check("ld_h_signed", rs1_a, 32'hFFFF_80F0);
    wb_en_i = 1; ld_unsigned_i = 1; tick(); wb_en_i = 0; #1;
    check("ld_h_unsigned", rs1_a, 32'h0000_80F0);
    wb_en_i = 1; ld_unsigned_i = 0; ld_size_i = 2'b11; mem_data_i = 32'h8000_80F0;
    tick(); wb_en_i = 0; #1;
    check("ld_sz11_word", rs1_a, 32'h8000_80F0);
    is_load_i = 0; tick();
    wb_en_i = 1; ld_size_i = SZ_BYTE; #1;
    check("not_load_no_ext", rs1_a, 32'h8000_80F0);
    wb_en_i = 0; wb_sel_mem_i = 0; ld_size_i = SZ_WORD; tick();

    // x0 is never written and never bypassed
    wb_alu(0, 32'hDEAD); rs1_addr_i = 0; #1;
    check("x0_bypass", rs1_a, 0);
    tick(); wb_en_i = 0; #1;
    check("x0_stored", rs1_a, 0);

    // Same-cycle bypass on both instances
    wb_alu(7, 32'hBEEF); rs1_addr_i = 7; rs2_addr_i = 7; #1;
    check("byp_rs1_on", rs1_a, 32'hBEEF);
    check("byp_rs2_on", rs2_a, 32'hBEEF);
    check("byp_rs1_off", rs1_b, 0);
    tick(); wb_en_i = 0; #1;
    check("x7_after_nobyp", rs1_b, 32'hBEEF);

    // Stall blocks the write and the bypass
    stall_i = 1; wb_alu(7, 32'h1111); #1;
    check("stall_no_bypass", rs1_a, 32'hBEEF);
    tick(); wb_en_i = 0; stall_i = 0; #1;
    check("stall_no_write", rs1_a, 32'hBEEF);

    // Store narrowing on rs2 only
    wb_alu(8, 32'h1234_5680); tick(); wb_en_i = 0;
    rs1_addr_i = 8; rs2_addr_i = 8; is_store_i = 1; st_size_i = SZ_BYTE; #1;
    check("st_byte", rs2_a, 32'hFFFF_FF80);
    check("st_rs1_untouched", rs1_a, 32'h1234_5680);
    st_size_i = SZ_HALF; #1;
    check("st_half", rs2_a, 32'h0000_5680);
    st_size_i = SZ_WORD; #1;
    check("st_word", rs2_a, 32'h1234_5680);
    st_size_i = 2'b11; #1;
    check("st_sz11_word", rs2_a, 32'h1234_5680);
    is_store_i = 0; st_size_i = SZ_BYTE; #1;
    check("not_store_no_narrow", rs2_a, 32'h1234_5680);
    st_size_i = SZ_WORD;

    // ECALL: busy asserts combinationally in IDLE, then WAIT holds for 5 cycles
    rs1_addr_i = 10; ecall_req_i = 1; #1;
    check("ecall_busy_idle", {31'd0, busy_a}, 1);
    check("ecall_ready_idle", {31'd0, ready_a}, 0);
    tick(); ecall_req_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wait_busy", {31'd0, busy_a}, 1);
      check("wait_ready", {31'd0, ready_a}, 1);
      tick();
    end
    check("wait_state", {31'd0, st_a}, {31'd0, ST_WAIT});
    key_valid_i = 1; key_data_i = 32'h2A; wb_alu(10, 32'h7); #1;
    check("xfer_busy", {31'd0, busy_a}, 1);
    tick(); key_valid_i = 0; wb_en_i = 0; #1;
    check("x10_key_wins", rs1_a, 32'h2A);
    check("busy_drop", {31'd0, busy_a}, 0);
    check("ready_drop", {31'd0, ready_a}, 0);

    // Keyboard write ignores stall; a request while in WAIT does not nest
    ecall_req_i = 1; tick(); stall_i = 1;
    key_valid_i = 1; key_data_i = 32'h33; #1;
    tick(); key_valid_i = 0; ecall_req_i = 0; stall_i = 0; #1;
    check("key_under_stall", rs1_a, 32'h33);
    check("no_nest_state", {31'd0, st_a}, {31'd0, ST_IDLE});

    // Reset during WAIT abandons the ECALL
    ecall_req_i = 1; tick(); ecall_req_i = 0; #1;
    check("pre_rst_wait", {31'd0, st_a}, {31'd0, ST_WAIT});
    key_data_i = 32'h99; key_valid_i = 1; reset = 0; #1;
    check("rst_wait_ready", {31'd0, ready_a}, 0);
    check("rst_wait_busy", {31'd0, busy_a}, 0);
    check("rst_wait_x10", rs1_a, 0);
    tick(); reset = 1; tick(); key_valid_i = 0; #1;
    check("post_rst_x10", rs1_a, 0);
    check("post_rst_state", {31'd0, st_a}, {31'd0, ST_IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
